// File: rtl/debounce_autorepeat.sv
// Two-button debouncer with press-and-hold auto-repeat, producing single-cycle
// increment/decrement enables for a downstream up/down counter.
module debounce_autorepeat #(
    parameter int DEB_CYCLES = 1000000,
    parameter int REP_DELAY  = 50000000,
    parameter int REP_PERIOD = 20000000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    output logic enUP,
    output logic enDOWN,
    output logic active
);

    localparam int DEB_W   = $clog2(DEB_CYCLES) + 1;
    localparam int REP_MAX = (REP_DELAY > REP_PERIOD) ? REP_DELAY : REP_PERIOD;
    localparam int REP_W   = $clog2(REP_MAX) + 1;

    localparam logic [DEB_W-1:0] DEB_LAST    = DEB_W'(DEB_CYCLES - 1);
    localparam logic [REP_W-1:0] DELAY_LAST  = REP_W'(REP_DELAY - 1);
    localparam logic [REP_W-1:0] PERIOD_LAST = REP_W'(REP_PERIOD - 1);

    localparam int UP   = 0;
    localparam int DOWN = 1;

    typedef enum logic [1:0] {
        IDLE,
        DELAY,
        REPEAT,
        LOCK
    } state_t;

    typedef enum logic {
        DIR_UP,
        DIR_DOWN
    } dir_t;

    function automatic logic [DEB_W-1:0] deb_inc(input logic [DEB_W-1:0] cnt);
        return (cnt == {DEB_W{1'b1}}) ? cnt : cnt + DEB_W'(1);
    endfunction

    function automatic logic [REP_W-1:0] rep_inc(input logic [REP_W-1:0] cnt);
        return (cnt == {REP_W{1'b1}}) ? cnt : cnt + REP_W'(1);
    endfunction

    logic [1:0]            sync_p0;
    logic [1:0]            sync_p1;
    logic [1:0]            deb;
    logic [1:0][DEB_W-1:0] deb_cnt;

    state_t            state_q;
    state_t            state_d;
    dir_t              dir_q;
    dir_t              dir_d;
    logic [REP_W-1:0]  rep_cnt_q;
    logic [REP_W-1:0]  rep_cnt_d;
    logic              up_d;
    logic              down_d;
    logic              held;
    logic              other;
    logic [REP_W-1:0]  rep_last;

    // Stage p0/p1: two-flop synchronizer for both raw buttons
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= {btn_down, btn_up};
            sync_p1 <= sync_p0;
        end
    end

    // Debounce: level flips only after DEB_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            deb     <= '0;
            deb_cnt <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_p1[i] == deb[i]) begin
                    deb_cnt[i] <= '0;
                end else if (deb_cnt[i] == DEB_LAST) begin
                    deb[i]     <= sync_p1[i];
                    deb_cnt[i] <= '0;
                end else begin
                    deb_cnt[i] <= deb_inc(deb_cnt[i]);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            dir_q     <= DIR_UP;
            rep_cnt_q <= '0;
            enUP      <= 1'b0;
            enDOWN    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            rep_cnt_q <= rep_cnt_d;
            enUP      <= up_d;
            enDOWN    <= down_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        rep_cnt_d = '0;
        up_d      = 1'b0;
        down_d    = 1'b0;
        held      = (dir_q == DIR_UP) ? deb[UP] : deb[DOWN];
        other     = (dir_q == DIR_UP) ? deb[DOWN] : deb[UP];
        rep_last  = (state_q == DELAY) ? DELAY_LAST : PERIOD_LAST;

        case (state_q)
            IDLE: begin
                if (deb[UP] && deb[DOWN]) begin
                    state_d = LOCK;
                end else if (deb[UP]) begin
                    up_d    = 1'b1;
                    dir_d   = DIR_UP;
                    state_d = DELAY;
                end else if (deb[DOWN]) begin
                    down_d  = 1'b1;
                    dir_d   = DIR_DOWN;
                    state_d = DELAY;
                end
            end
            DELAY, REPEAT: begin
                // Conflict and release both take priority over a due repeat pulse
                if (other) begin
                    state_d = LOCK;
                end else if (!held) begin
                    state_d = IDLE;
                end else if (rep_cnt_q == rep_last) begin
                    up_d    = (dir_q == DIR_UP);
                    down_d  = (dir_q == DIR_DOWN);
                    state_d = REPEAT;
                end else begin
                    rep_cnt_d = rep_inc(rep_cnt_q);
                end
            end
            LOCK: begin
                if (!deb[UP] && !deb[DOWN]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign active = (state_q != IDLE);

endmodule

// File: tb/tb_debounce_autorepeat.sv
// Directed bench for debounce_autorepeat with short debounce/repeat timings.
module tb_debounce_autorepeat;

    localparam int DEB_CYCLES = 4;
    localparam int REP_DELAY  = 10;
    localparam int REP_PERIOD = 5;
    // Press driven after edge N: sync at N+1,N+2, debounce N+3..N+6, pulse after N+7
    localparam int LAT = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_up = 1'b0;
    logic btn_down = 1'b0;
    logic enUP;
    logic enDOWN;
    logic active;

    int edge_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;
    int up_t[$];
    int dn_t[$];
    int overlap_err = 0;
    int width_err = 0;
    int adj_err = 0;
    logic prev_up = 1'b0;
    logic prev_dn = 1'b0;

    debounce_autorepeat #(
        .DEB_CYCLES(DEB_CYCLES),
        .REP_DELAY (REP_DELAY),
        .REP_PERIOD(REP_PERIOD)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .enUP    (enUP),
        .enDOWN  (enDOWN),
        .active  (active)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    always @(negedge clk) begin
        if (enUP) up_t.push_back(edge_cnt);
        if (enDOWN) dn_t.push_back(edge_cnt);
        if (enUP && enDOWN) overlap_err <= overlap_err + 1;
        if ((enUP && prev_up) || (enDOWN && prev_dn)) width_err <= width_err + 1;
        if ((enUP && prev_dn) || (enDOWN && prev_up)) adj_err <= adj_err + 1;
        prev_up <= enUP;
        prev_dn <= enDOWN;
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic clear_mon();
        up_t.delete();
        dn_t.delete();
    endtask

    function automatic int first_lat(input int t[$], input int base);
        return (t.size() > 0) ? t[0] - base : -1;
    endfunction

    int n0;
    int gaps_exp [6] = '{10, 5, 5, 5, 5, 5};

    initial begin
        tick(3);
        check_val("rst_enUP", enUP, 0);
        check_val("rst_enDOWN", enDOWN, 0);
        check_val("rst_active", active, 0);
        reset = 1'b0;
        tick(3);

        // Single clean press
        clear_mon();
        n0 = edge_cnt;
        btn_up = 1'b1;
        tick(8);
        check_val("single_active_held", active, 1);
        btn_up = 1'b0;
        tick(10);
        check_val("single_up_count", up_t.size(), 1);
        check_val("single_up_latency", first_lat(up_t, n0), LAT);
        check_val("single_down_count", dn_t.size(), 0);
        check_val("single_active_end", active, 0);

        // Bouncing press then steady hold
        clear_mon();
        n0 = edge_cnt;
        for (int i = 0; i < 6; i++) begin
            btn_up = (i % 2 == 0);
            tick(2);
        end
        check_val("bounce_no_pulse", up_t.size(), 0);
        btn_up = 1'b1;
        tick(8);
        btn_up = 1'b0;
        tick(12);
        check_val("bounce_up_count", up_t.size(), 1);
        check_val("bounce_up_time", first_lat(up_t, n0), 12 + LAT);
        check_val("bounce_active_end", active, 0);

        // Held down button auto-repeats
        clear_mon();
        n0 = edge_cnt;
        btn_down = 1'b1;
        tick(38);
        btn_down = 1'b0;
        tick(20);
        check_val("hold_down_count", dn_t.size(), 7);
        check_val("hold_up_count", up_t.size(), 0);
        check_val("hold_down_latency", first_lat(dn_t, n0), LAT);
        for (int i = 1; i < 7; i++) begin
            if (i < dn_t.size())
                check_val($sformatf("hold_gap%0d", i), dn_t[i] - dn_t[i-1], gaps_exp[i-1]);
        end
        check_val("hold_active_end", active, 0);

        // Simultaneous press locks out
        clear_mon();
        btn_up = 1'b1;
        btn_down = 1'b1;
        tick(10);
        check_val("both_active_lock", active, 1);
        tick(10);
        btn_up = 1'b0;
        btn_down = 1'b0;
        tick(10);
        check_val("both_active_end", active, 0);
        check_val("both_no_up", up_t.size(), 0);
        check_val("both_no_down", dn_t.size(), 0);
        n0 = edge_cnt;
        btn_up = 1'b1;
        tick(8);
        btn_up = 1'b0;
        tick(10);
        check_val("after_lock_up_count", up_t.size(), 1);
        check_val("after_lock_latency", first_lat(up_t, n0), LAT);

        // Opposite button during repeat
        clear_mon();
        n0 = edge_cnt;
        btn_up = 1'b1;
        tick(19);
        btn_down = 1'b1;
        tick(21);
        check_val("opp_up_count", up_t.size(), 3);
        check_val("opp_down_count", dn_t.size(), 0);
        check_val("opp_active_both", active, 1);
        if (up_t.size() > 1) check_val("opp_up_gap", up_t[1] - up_t[0], REP_DELAY);
        btn_up = 1'b0;
        tick(10);
        check_val("opp_active_down_only", active, 1);
        check_val("opp_down_count2", dn_t.size(), 0);
        btn_down = 1'b0;
        tick(10);
        check_val("opp_active_end", active, 0);
        check_val("opp_up_count_end", up_t.size(), 3);

        // Release coinciding with first repeat expiry emits nothing extra
        clear_mon();
        btn_up = 1'b1;
        tick(10);
        btn_up = 1'b0;
        tick(12);
        check_val("tie_up_count", up_t.size(), 1);
        check_val("tie_active_end", active, 0);

        // Asynchronous reset during a repeat pulse
        clear_mon();
        btn_up = 1'b1;
        tick(22);
        check_val("arst_pre_enUP", enUP, 1);
        reset = 1'b1;
        #1;
        check_val("arst_enUP", enUP, 0);
        check_val("arst_enDOWN", enDOWN, 0);
        check_val("arst_active", active, 0);
        tick(3);
        clear_mon();
        n0 = edge_cnt;
        reset = 1'b0;
        tick(8);
        btn_up = 1'b0;
        tick(12);
        check_val("arst_up_count", up_t.size(), 1);
        check_val("arst_up_latency", first_lat(up_t, n0), LAT);
        check_val("arst_down_count", dn_t.size(), 0);

        check_val("pulse_overlap", overlap_err, 0);
        check_val("pulse_width", width_err, 0);
        check_val("pulse_adjacent", adj_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
